// File: rtl/ram_dp_param.sv
// ram_dp_param: true dual-port RAM with a shared clock, read-first ports,
// registered CE output gating and an optional whole-array clear engine.
// Build option: define RAM_DP_PARAM_CLR_EN to include the clear engine
// (IDLE/CLEAR FSM, address counter, I_CLR, O_BUSY).
// Without it, I_CLR is ignored and O_BUSY is tied low.
module ram_dp_param #(
  parameter int            AW      = 10,
  parameter int            DW      = 8,
  parameter logic [DW-1:0] CLR_VAL = '0
) (
  input  logic          I_CLK,
  input  logic          I_RST,
  input  logic [AW-1:0] I_ADDRA,
  input  logic [DW-1:0] I_DA,
  input  logic          I_CEA,
  input  logic          I_WEA,
  output logic [DW-1:0] O_DA,
  input  logic [AW-1:0] I_ADDRB,
  input  logic [DW-1:0] I_DB,
  input  logic          I_CEB,
  input  logic          I_WEB,
  output logic [DW-1:0] O_DB,
  input  logic          I_CLR,
  output logic          O_BUSY
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] q_a_reg;
  logic [DW-1:0] q_b_reg;
  logic          cea_reg;
  logic          ceb_reg;
  logic          busy;
  logic [AW-1:0] clr_addr;

`ifdef RAM_DP_PARAM_CLR_EN
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state_reg;
  logic [AW-1:0] cnt_reg;
  logic          busy_reg;

  // Clear FSM: reset parks it in CLEAR at address 0, so releasing reset
  // starts a full sweep; I_CLR is only honoured from IDLE.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
      busy_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (I_CLR) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        CLEAR: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (&cnt_reg) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign clr_addr = cnt_reg;
`else
  logic unused_clr;

  assign busy       = 1'b0;
  assign clr_addr   = '0;
  assign unused_clr = I_CLR;
`endif

  assign O_BUSY = busy;

  // Array writes: the clear sweep owns the array while busy (during reset
  // it keeps rewriting address 0, which the sweep covers anyway); otherwise
  // B is written first so a same-address A write takes precedence.
  always_ff @(posedge I_CLK) begin
    if (busy) begin
      mem[clr_addr] <= CLR_VAL;
    end else begin
      if (I_CEB && I_WEB) begin
        mem[I_ADDRB] <= I_DB;
      end
      if (I_CEA && I_WEA) begin
        mem[I_ADDRA] <= I_DA;
      end
    end
  end

  // Registered reads sample the array before this edge's writes land,
  // giving read-first data on both ports.
  always_ff @(posedge I_CLK) begin
    if (I_CEA) begin
      q_a_reg <= mem[I_ADDRA];
    end
    if (I_CEB) begin
      q_b_reg <= mem[I_ADDRB];
    end
  end

  // Output qualifiers: a read only shows data if the port was enabled and
  // no clear was running when it was issued.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      cea_reg <= 1'b0;
      ceb_reg <= 1'b0;
    end else begin
      cea_reg <= I_CEA && !busy;
      ceb_reg <= I_CEB && !busy;
    end
  end

  assign O_DA = cea_reg ? q_a_reg : '0;
  assign O_DB = ceb_reg ? q_b_reg : '0;

endmodule

// File: tb/tb_ram_dp_param.sv
// tb_ram_dp_param: scoreboard bench for ram_dp_param (AW=4, DW=8,
// CLR_VAL=8'hA5). Clear-engine scenarios are selected by RAM_DP_PARAM_CLR_EN.
module tb_ram_dp_param;

  localparam int            AW      = 4;
  localparam int            DW      = 8;
  localparam logic [DW-1:0] CLR_VAL = 8'hA5;

  typedef struct packed {
    logic          cea;
    logic          wea;
    logic [AW-1:0] aa;
    logic [DW-1:0] da;
    logic          ceb;
    logic          web;
    logic [AW-1:0] ab;
    logic [DW-1:0] db;
  } op_t;

  logic          I_CLK = 1'b0;
  logic          I_RST = 1'b1;
  logic [AW-1:0] I_ADDRA = '0;
  logic [DW-1:0] I_DA = '0;
  logic          I_CEA = 1'b0;
  logic          I_WEA = 1'b0;
  logic [DW-1:0] O_DA;
  logic [AW-1:0] I_ADDRB = '0;
  logic [DW-1:0] I_DB = '0;
  logic          I_CEB = 1'b0;
  logic          I_WEB = 1'b0;
  logic [DW-1:0] O_DB;
  logic          I_CLR = 1'b0;
  logic          O_BUSY;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] exp_a [$];
  logic [DW-1:0] exp_b [$];
  logic [DW-1:0] dummy;

  always #5 I_CLK = ~I_CLK;

  ram_dp_param #(.AW(AW), .DW(DW), .CLR_VAL(CLR_VAL)) dut (
    .I_CLK  (I_CLK),
    .I_RST  (I_RST),
    .I_ADDRA(I_ADDRA),
    .I_DA   (I_DA),
    .I_CEA  (I_CEA),
    .I_WEA  (I_WEA),
    .O_DA   (O_DA),
    .I_ADDRB(I_ADDRB),
    .I_DB   (I_DB),
    .I_CEB  (I_CEB),
    .I_WEB  (I_WEB),
    .O_DB   (O_DB),
    .I_CLR  (I_CLR),
    .O_BUSY (O_BUSY)
  );

  function automatic op_t mk(input logic cea, input logic wea, input logic [AW-1:0] aa,
                             input logic [DW-1:0] da, input logic ceb, input logic web,
                             input logic [AW-1:0] ab, input logic [DW-1:0] db);
    op_t o;
    o.cea = cea; o.wea = wea; o.aa = aa; o.da = da;
    o.ceb = ceb; o.web = web; o.ab = ab; o.db = db;
    return o;
  endfunction

  // Drive one cycle; push expected read data (blk = clear running) and
  // update the reference array with the surviving writes.
  task automatic drive(input op_t o, input logic clr, input logic blk);
    I_CEA = o.cea; I_WEA = o.wea; I_ADDRA = o.aa; I_DA = o.da;
    I_CEB = o.ceb; I_WEB = o.web; I_ADDRB = o.ab; I_DB = o.db;
    I_CLR = clr;
    @(posedge I_CLK);
    #1;
    exp_a.push_back((o.cea && !blk) ? ref_mem[o.aa] : 8'h00);
    exp_b.push_back((o.ceb && !blk) ? ref_mem[o.ab] : 8'h00);
    if (!blk) begin
      if (o.ceb && o.web) ref_mem[o.ab] = o.db;
      if (o.cea && o.wea) ref_mem[o.aa] = o.da;
    end
    $display("txn A(ce=%0b we=%0b a=%0d d=%h) B(ce=%0b we=%0b a=%0d d=%h) clr=%0b -> DA=%h DB=%h busy=%0b",
             o.cea, o.wea, o.aa, o.da, o.ceb, o.web, o.ab, o.db, clr, O_DA, O_DB, O_BUSY);
    I_CLR = 1'b0;
    I_CEA = 1'b0; I_WEA = 1'b0; I_CEB = 1'b0; I_WEB = 1'b0;
  endtask

  task automatic test_reset();
    int busy_cnt;
    I_RST = 1'b1;
    repeat (2) @(posedge I_CLK);
    #1;
    total_cnt++;
    if (O_DA !== 8'h00) $display("FAIL reset_da: got %h want 00", O_DA); else pass_cnt++;
    total_cnt++;
    if (O_DB !== 8'h00) $display("FAIL reset_db: got %h want 00", O_DB); else pass_cnt++;
`ifdef RAM_DP_PARAM_CLR_EN
    total_cnt++;
    if (O_BUSY !== 1'b1) $display("FAIL reset_busy: got %b want 1", O_BUSY); else pass_cnt++;
    I_RST = 1'b0;
    busy_cnt = 0;
    while (O_BUSY === 1'b1 && busy_cnt < 100) begin
      busy_cnt++;
      @(posedge I_CLK);
      #1;
    end
    total_cnt++;
    if (busy_cnt != 16) $display("FAIL reset_clear_len: got %0d want 16", busy_cnt); else pass_cnt++;
    for (int i = 0; i < 16; i++) ref_mem[i] = CLR_VAL;
    for (int i = 0; i < 16; i++) begin
      drive(mk(1'b1, 1'b0, 4'(i), 8'h00, 1'b1, 1'b0, 4'(15 - i), 8'h00), 1'b0, 1'b0);
      total_cnt++;
      if (O_DA !== exp_a.pop_front() || O_DA !== CLR_VAL)
        $display("FAIL reset_fill_a addr %0d: got %h want %h", i, O_DA, CLR_VAL);
      else pass_cnt++;
      total_cnt++;
      if (O_DB !== exp_b.pop_front()) $display("FAIL reset_fill_b addr %0d: got %h want %h", 15 - i, O_DB, CLR_VAL);
      else pass_cnt++;
    end
`else
    total_cnt++;
    if (O_BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", O_BUSY); else pass_cnt++;
    I_RST = 1'b0;
    busy_cnt = 0;
    drive(mk(1'b1, 1'b1, 4'd0, 8'h5A, 1'b0, 1'b0, 4'd0, 8'h00), 1'b0, 1'b0);
    dummy = exp_a.pop_front();
    total_cnt++;
    if (O_DB !== exp_b.pop_front()) $display("FAIL first_write_db: got %h want 00", O_DB); else pass_cnt++;
    total_cnt++;
    if (O_BUSY !== 1'b0) $display("FAIL first_write_busy: got %b want 0", O_BUSY); else pass_cnt++;
    drive(mk(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd0, 8'h00), 1'b0, 1'b0);
    total_cnt++;
    if (O_DA !== exp_a.pop_front()) $display("FAIL first_read_da: got %h want 00", O_DA); else pass_cnt++;
    total_cnt++;
    if (O_DB !== exp_b.pop_front() || O_DB !== 8'h5A) $display("FAIL first_read_db: got %h want 5a", O_DB);
    else pass_cnt++;
`endif
  endtask

  // Give every address a known value so later reads are well defined.
  task automatic fill_mem();
    for (int i = 0; i < 8; i++) begin
      drive(mk(1'b1, 1'b1, 4'(2 * i), 8'(16 * i + 1), 1'b1, 1'b1, 4'(2 * i + 1), 8'(16 * i + 2)),
            1'b0, 1'b0);
      dummy = exp_a.pop_front();
      dummy = exp_b.pop_front();
    end
  endtask

  task automatic test_write_read();
    op_t ops [5];
    ops[0] = mk(1'b1, 1'b1, 4'd5, 8'h3C, 1'b0, 1'b0, 4'd0, 8'h00);
    ops[1] = mk(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd5, 8'h00);
    ops[2] = mk(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd5, 8'h00);
    ops[3] = mk(1'b0, 1'b1, 4'd5, 8'h99, 1'b0, 1'b1, 4'd5, 8'h98);
    ops[4] = mk(1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 1'b0, 4'd5, 8'h00);
    for (int s = 0; s < 5; s++) begin
      drive(ops[s], 1'b0, 1'b0);
      total_cnt++;
      if (O_DA !== exp_a.pop_front()) $display("FAIL write_read_a step %0d: got %h", s, O_DA); else pass_cnt++;
      total_cnt++;
      if (O_DB !== exp_b.pop_front()) $display("FAIL write_read_b step %0d: got %h", s, O_DB); else pass_cnt++;
      if (s == 1) begin
        total_cnt++;
        if (O_DB !== 8'h3C) $display("FAIL write_read_const: got %h want 3c", O_DB); else pass_cnt++;
      end
    end
  endtask

  task automatic test_collision();
    op_t ops [6];
    ops[0] = mk(1'b1, 1'b1, 4'd7, 8'h11, 1'b0, 1'b0, 4'd0, 8'h00);
    ops[1] = mk(1'b1, 1'b1, 4'd7, 8'h22, 1'b1, 1'b1, 4'd7, 8'h33);
    ops[2] = mk(1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 1'b0, 4'd7, 8'h00);
    ops[3] = mk(1'b1, 1'b1, 4'd9, 8'h44, 1'b1, 1'b0, 4'd9, 8'h00);
    ops[4] = mk(1'b1, 1'b0, 4'd9, 8'h00, 1'b1, 1'b1, 4'd9, 8'h55);
    ops[5] = mk(1'b1, 1'b0, 4'd9, 8'h00, 1'b1, 1'b0, 4'd9, 8'h00);
    for (int s = 0; s < 6; s++) begin
      drive(ops[s], 1'b0, 1'b0);
      total_cnt++;
      if (O_DA !== exp_a.pop_front()) $display("FAIL collision_a step %0d: got %h", s, O_DA); else pass_cnt++;
      total_cnt++;
      if (O_DB !== exp_b.pop_front()) $display("FAIL collision_b step %0d: got %h", s, O_DB); else pass_cnt++;
      if (s == 1) begin
        total_cnt++;
        if (O_DA !== 8'h11 || O_DB !== 8'h11) $display("FAIL rdw_old: got %h/%h want 11/11", O_DA, O_DB);
        else pass_cnt++;
      end
      if (s == 2) begin
        total_cnt++;
        if (O_DA !== 8'h22) $display("FAIL collision_winner: got %h want 22", O_DA); else pass_cnt++;
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t o;
    for (int s = 0; s < 60; s++) begin
      o = mk(1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom),
             1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
      drive(o, 1'b0, 1'b0);
      total_cnt++;
      if (O_DA !== exp_a.pop_front()) $display("FAIL b2b_a step %0d: got %h", s, O_DA); else pass_cnt++;
      total_cnt++;
      if (O_DB !== exp_b.pop_front()) $display("FAIL b2b_b step %0d: got %h", s, O_DB); else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    int busy_cnt;
    ref_mem[12] = ref_mem[12];
    drive(mk(1'b1, 1'b1, 4'd12, 8'h77, 1'b0, 1'b0, 4'd0, 8'h00), 1'b0, 1'b0);
    dummy = exp_a.pop_front();
    dummy = exp_b.pop_front();
    drive(mk(1'b1, 1'b0, 4'd12, 8'h00, 1'b1, 1'b0, 4'd12, 8'h00), 1'b0, 1'b0);
    total_cnt++;
    if (O_DA !== exp_a.pop_front() || O_DA !== 8'h77) $display("FAIL pre_rst_a: got %h want 77", O_DA);
    else pass_cnt++;
    dummy = exp_b.pop_front();
    I_RST = 1'b1;
    #2;
    total_cnt++;
    if (O_DA !== 8'h00 || O_DB !== 8'h00) $display("FAIL async_rst_out: got %h/%h want 00/00", O_DA, O_DB);
    else pass_cnt++;
    @(posedge I_CLK);
    #1;
    I_RST = 1'b0;
`ifdef RAM_DP_PARAM_CLR_EN
    busy_cnt = 0;
    while (O_BUSY === 1'b1 && busy_cnt < 100) begin
      busy_cnt++;
      @(posedge I_CLK);
      #1;
    end
    total_cnt++;
    if (busy_cnt != 16) $display("FAIL async_rst_clear_len: got %0d want 16", busy_cnt); else pass_cnt++;
    for (int i = 0; i < 16; i++) ref_mem[i] = CLR_VAL;
`else
    busy_cnt = 0;
    total_cnt++;
    if (O_BUSY !== 1'b0) $display("FAIL async_rst_busy: got %b want 0", O_BUSY); else pass_cnt++;
`endif
    drive(mk(1'b1, 1'b0, 4'd12, 8'h00, 1'b1, 1'b0, 4'd0, 8'h00), 1'b0, 1'b0);
    total_cnt++;
    if (O_DA !== exp_a.pop_front()) $display("FAIL post_rst_a: got %h", O_DA); else pass_cnt++;
    total_cnt++;
    if (O_DB !== exp_b.pop_front()) $display("FAIL post_rst_b: got %h", O_DB); else pass_cnt++;
  endtask

`ifdef RAM_DP_PARAM_CLR_EN
  task automatic test_clear();
    op_t o;
    logic clr;
    int busy_cnt;
    drive(mk(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00), 1'b1, 1'b0);
    dummy = exp_a.pop_front();
    dummy = exp_b.pop_front();
    total_cnt++;
    if (O_BUSY !== 1'b1) $display("FAIL clear_start: got %b want 1", O_BUSY); else pass_cnt++;
    busy_cnt = (O_BUSY === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 16; k++) begin
      o = mk(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
      clr = 1'b0;
      if (k == 2) o = mk(1'b1, 1'b1, 4'd3, 8'hFF, 1'b1, 1'b0, 4'd3, 8'h00);
      if (k == 5) o = mk(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
      if (k == 8) clr = 1'b1;
      drive(o, clr, 1'b1);
      if (O_BUSY === 1'b1) busy_cnt++;
      total_cnt++;
      if (O_BUSY !== (k < 16)) $display("FAIL clear_busy k=%0d: got %b want %b", k, O_BUSY, (k < 16));
      else pass_cnt++;
      total_cnt++;
      if (O_DA !== exp_a.pop_front() || O_DB !== exp_b.pop_front())
        $display("FAIL clear_read_zero k=%0d: got %h/%h want 00/00", k, O_DA, O_DB);
      else pass_cnt++;
    end
    total_cnt++;
    if (busy_cnt != 16) $display("FAIL clear_len: got %0d want 16", busy_cnt); else pass_cnt++;
    for (int i = 0; i < 16; i++) ref_mem[i] = CLR_VAL;
    for (int i = 0; i < 16; i++) begin
      drive(mk(1'b1, 1'b0, 4'(i), 8'h00, 1'b1, 1'b0, 4'((i + 3) % 16), 8'h00), 1'b0, 1'b0);
      total_cnt++;
      if (O_DA !== exp_a.pop_front()) $display("FAIL clear_fill_a addr %0d: got %h want a5", i, O_DA);
      else pass_cnt++;
      total_cnt++;
      if (O_DB !== exp_b.pop_front()) $display("FAIL clear_fill_b addr %0d: got %h want a5", (i + 3) % 16, O_DB);
      else pass_cnt++;
      if (i == 3) begin
        total_cnt++;
        if (O_DA !== 8'hA5) $display("FAIL clear_addr3: got %h want a5", O_DA); else pass_cnt++;
      end
    end
  endtask

  task automatic test_rst_mid_clear();
    int busy_cnt;
    drive(mk(1'b1, 1'b1, 4'd12, 8'h77, 1'b1, 1'b1, 4'd14, 8'h66), 1'b0, 1'b0);
    dummy = exp_a.pop_front();
    dummy = exp_b.pop_front();
    drive(mk(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00), 1'b1, 1'b0);
    dummy = exp_a.pop_front();
    dummy = exp_b.pop_front();
    for (int k = 1; k <= 9; k++) begin
      drive(mk(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00), 1'b0, 1'b1);
      dummy = exp_a.pop_front();
      dummy = exp_b.pop_front();
    end
    I_RST = 1'b1;
    #2;
    total_cnt++;
    if (O_BUSY !== 1'b1) $display("FAIL mid_rst_busy: got %b want 1", O_BUSY); else pass_cnt++;
    @(posedge I_CLK);
    #1;
    I_RST = 1'b0;
    busy_cnt = 0;
    while (O_BUSY === 1'b1 && busy_cnt < 100) begin
      busy_cnt++;
      @(posedge I_CLK);
      #1;
    end
    total_cnt++;
    if (busy_cnt != 16) $display("FAIL mid_rst_clear_len: got %0d want 16", busy_cnt); else pass_cnt++;
    for (int i = 0; i < 16; i++) ref_mem[i] = CLR_VAL;
    drive(mk(1'b1, 1'b0, 4'd12, 8'h00, 1'b1, 1'b0, 4'd14, 8'h00), 1'b0, 1'b0);
    total_cnt++;
    if (O_DA !== exp_a.pop_front()) $display("FAIL mid_rst_addr12: got %h want a5", O_DA); else pass_cnt++;
    total_cnt++;
    if (O_DB !== exp_b.pop_front()) $display("FAIL mid_rst_addr14: got %h want a5", O_DB); else pass_cnt++;
  endtask
`else
  task automatic test_clr_ignored();
    op_t ops [4];
    ops[0] = mk(1'b1, 1'b1, 4'd2, 8'h3E, 1'b1, 1'b1, 4'd6, 8'h4D);
    ops[1] = mk(1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 4'd6, 8'h00);
    ops[2] = mk(1'b1, 1'b1, 4'd0, 8'hC3, 1'b1, 1'b0, 4'd2, 8'h00);
    ops[3] = mk(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd6, 8'h00);
    for (int s = 0; s < 4; s++) begin
      drive(ops[s], 1'b1, 1'b0);
      total_cnt++;
      if (O_BUSY !== 1'b0) $display("FAIL clr_ign_busy step %0d: got %b want 0", s, O_BUSY); else pass_cnt++;
      total_cnt++;
      if (O_DA !== exp_a.pop_front()) $display("FAIL clr_ign_a step %0d: got %h", s, O_DA); else pass_cnt++;
      total_cnt++;
      if (O_DB !== exp_b.pop_front()) $display("FAIL clr_ign_b step %0d: got %h", s, O_DB); else pass_cnt++;
    end
  endtask
`endif

  initial begin
    test_reset();
    fill_mem();
    test_write_read();
    test_collision();
    test_back_to_back();
    test_async_reset();
`ifdef RAM_DP_PARAM_CLR_EN
    test_clear();
    test_rst_mid_clear();
`else
    test_clr_ignored();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
